// File: rtl/generador_ficha.sv
// 2048 tile spawner: drops one 2/4 tile (two on a new game) into a pseudo-random empty
// cell of the post-move board, then flags win/loss and returns the board.
module generador_ficha #(
    parameter int          ANCHO   = 12,
    parameter int          META    = 2048,
    parameter logic [15:0] SEMILLA = 16'hACE1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        limpiar,
    input  logic [0:3][0:3][ANCHO-1:0]  matriz_in,
    output logic [0:3][0:3][ANCHO-1:0]  matriz_out,
    output logic                        ocupado,
    output logic                        done,
    output logic                        gano,
    output logic                        perdio
);

    typedef enum logic [2:0] {IDLE, CONTAR, ELEGIR, EVALUAR, FIN} estado_t;

    localparam logic [ANCHO-1:0] VALOR_META = META[ANCHO-1:0];

    estado_t                    r_estado;
    estado_t                    w_estado_n;
    logic [15:0]                r_lfsr;
    logic [11:0]                r_rnd;
    logic [0:3][0:3][ANCHO-1:0] r_tablero;
    logic [3:0]                 r_idx;
    logic [4:0]                 r_vacias;
    logic [4:0]                 r_vistas;
    logic [4:0]                 r_objetivo;
    logic [1:0]                 r_pendientes;
    logic                       r_gano_n;
    logic                       r_perdio_n;

    logic                       w_lfsr_fb;
    logic [ANCHO-1:0]           w_celda;
    logic                       w_celda_vacia;
    logic [4:0]                 w_vacias_fin;
    logic [4:0]                 w_objetivo;
    logic                       w_acierto;
    logic [ANCHO-1:0]           w_ficha;
    logic                       w_gano_n;
    logic                       w_hay_vacia;
    logic                       w_hay_par;

    // Taps 16,14,13,11 of x^16+x^14+x^13+x^11+1.
    assign w_lfsr_fb     = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_celda       = r_tablero[r_idx[3:2]][r_idx[1:0]];
    assign w_celda_vacia = (w_celda == '0);
    assign w_vacias_fin  = r_vacias + {4'd0, w_celda_vacia};
    assign w_objetivo    = 5'(({5'd0, r_rnd[7:0]} * {8'd0, w_vacias_fin}) >> 8);
    assign w_acierto     = (r_estado == ELEGIR) && w_celda_vacia && (r_vistas == r_objetivo);
    assign w_ficha       = (r_rnd[11:8] < 4'd2) ? ANCHO'(4) : ANCHO'(2);
    assign ocupado       = (r_estado != IDLE);

    // Win/loss evaluation over the whole board: 16 cell tests plus 24 neighbour pairs.
    always_comb begin
        w_gano_n    = 1'b0;
        w_hay_vacia = 1'b0;
        w_hay_par   = 1'b0;
        for (int f = 0; f < 4; f++) begin
            for (int c = 0; c < 4; c++) begin
                if (r_tablero[f][c] == VALOR_META) w_gano_n = 1'b1;
                if (r_tablero[f][c] == '0)         w_hay_vacia = 1'b1;
            end
        end
        for (int f = 0; f < 4; f++) begin
            for (int c = 0; c < 3; c++) begin
                if (r_tablero[f][c] != '0 && r_tablero[f][c] == r_tablero[f][c+1]) w_hay_par = 1'b1;
            end
        end
        for (int f = 0; f < 3; f++) begin
            for (int c = 0; c < 4; c++) begin
                if (r_tablero[f][c] != '0 && r_tablero[f][c] == r_tablero[f+1][c]) w_hay_par = 1'b1;
            end
        end
    end

    always_comb begin
        w_estado_n = r_estado;
        case (r_estado)
            IDLE:    if (start) w_estado_n = CONTAR;
            CONTAR:  if (r_idx == 4'd15) w_estado_n = (w_vacias_fin == 5'd0) ? EVALUAR : ELEGIR;
            ELEGIR: begin
                if (w_acierto)            w_estado_n = (r_pendientes > 2'd1) ? CONTAR : EVALUAR;
                else if (r_idx == 4'd15)  w_estado_n = EVALUAR;
            end
            EVALUAR: w_estado_n = FIN;
            FIN:     w_estado_n = IDLE;
            default: w_estado_n = IDLE;
        endcase
    end

    // NOTE: every register here is assigned with <= so all of them sample the pre-edge
    // values; a blocking write would let later statements see the new value mid-block.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_estado     <= IDLE;
            r_lfsr       <= SEMILLA;
            r_rnd        <= '0;
            r_tablero    <= '0;
            r_idx        <= '0;
            r_vacias     <= '0;
            r_vistas     <= '0;
            r_objetivo   <= '0;
            r_pendientes <= '0;
            r_gano_n     <= 1'b0;
            r_perdio_n   <= 1'b0;
            matriz_out   <= '0;
            done         <= 1'b0;
            gano         <= 1'b0;
            perdio       <= 1'b0;
        end else begin
            r_estado <= w_estado_n;
            r_lfsr   <= {r_lfsr[14:0], w_lfsr_fb};
            done     <= 1'b0;
            case (r_estado)
                IDLE: begin
                    if (start) begin
                        r_tablero    <= limpiar ? '0 : matriz_in;
                        r_pendientes <= limpiar ? 2'd2 : 2'd1;
                        r_rnd        <= r_lfsr[11:0];
                        r_idx        <= '0;
                        r_vacias     <= '0;
                    end
                end
                CONTAR: begin
                    r_idx    <= r_idx + 4'd1;
                    r_vacias <= w_vacias_fin;
                    r_vistas <= '0;
                    if (r_idx == 4'd15) r_objetivo <= w_objetivo;
                end
                ELEGIR: begin
                    r_idx <= r_idx + 4'd1;
                    if (w_celda_vacia) r_vistas <= r_vistas + 5'd1;
                    if (w_acierto) begin
                        r_tablero[r_idx[3:2]][r_idx[1:0]] <= w_ficha;
                        r_pendientes <= r_pendientes - 2'd1;
                        r_rnd        <= r_lfsr[11:0];
                        r_idx        <= '0;
                        r_vacias     <= '0;
                    end
                end
                EVALUAR: begin
                    r_gano_n   <= w_gano_n;
                    r_perdio_n <= !w_hay_vacia && !w_hay_par;
                end
                FIN: begin
                    matriz_out <= r_tablero;
                    gano       <= r_gano_n;
                    perdio     <= r_perdio_n;
                    done       <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_generador_ficha.sv
// Scoreboard bench for generador_ficha: the driver queues the expected result of each pass
// and a monitor checks it when done pulses.
module tb_generador_ficha;

    typedef logic [0:3][0:3][11:0] tablero_t;

    typedef struct {
        int       id;
        int       t_start;
        int       lat_min;
        int       lat_max;
        tablero_t tablero;     // cells flagged in libre hold 12'hFFF
        logic [15:0] libre;    // cells that must have received a 2 or 4
        bit       modo_limpiar;
        logic     gano;
        logic     perdio;
    } esperado_t;

    logic     clk = 1'b0;
    logic     rst;
    logic     start;
    logic     limpiar;
    tablero_t matriz_in;
    tablero_t matriz_out;
    logic     ocupado;
    logic     done;
    logic     gano;
    logic     perdio;

    int total = 0;
    int bad   = 0;
    int ciclo = 0;
    esperado_t cola[$];

    generador_ficha dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .limpiar    (limpiar),
        .matriz_in  (matriz_in),
        .matriz_out (matriz_out),
        .ocupado    (ocupado),
        .done       (done),
        .gano       (gano),
        .perdio     (perdio)
    );

    always #5 clk = ~clk;
    always @(posedge clk) ciclo <= ciclo + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nombre, input logic [191:0] act, input logic [191:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", nombre, act, req);
        end
    endtask

    // Monitor: compares every done pulse against the head of the scoreboard.
    initial begin : monitor
        esperado_t e;
        tablero_t  vista;
        int        lat;
        int        nz;
        int        raros;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (cola.size() == 0) begin
                    check("done_inesperado", 1, 0);
                end else begin
                    e   = cola.pop_front();
                    lat = ciclo - e.t_start;
                    if (e.lat_min == e.lat_max)
                        check($sformatf("t%0d latencia", e.id), lat, e.lat_min);
                    else
                        check($sformatf("t%0d latencia_rango(lat=%0d)", e.id, lat),
                              (lat >= e.lat_min && lat <= e.lat_max), 1);
                    if (e.modo_limpiar) begin
                        nz = 0;
                        raros = 0;
                        for (int f = 0; f < 4; f++)
                            for (int c = 0; c < 4; c++)
                                if (matriz_out[f][c] != 0) begin
                                    nz++;
                                    if (matriz_out[f][c] != 2 && matriz_out[f][c] != 4) raros++;
                                end
                        check($sformatf("t%0d fichas_nuevas", e.id), nz, 2);
                        check($sformatf("t%0d valores_nuevos", e.id), raros, 0);
                    end else begin
                        vista = matriz_out;
                        for (int f = 0; f < 4; f++)
                            for (int c = 0; c < 4; c++)
                                if (e.libre[4*f+c] && (vista[f][c] == 2 || vista[f][c] == 4))
                                    vista[f][c] = 12'hFFF;
                        check($sformatf("t%0d tablero", e.id), vista, e.tablero);
                    end
                    check($sformatf("t%0d gano", e.id), gano, e.gano);
                    check($sformatf("t%0d perdio", e.id), perdio, e.perdio);
                    @(negedge clk);
                    check($sformatf("t%0d done_pulso", e.id), done, 0);
                end
            end
        end
    end

    task automatic lanzar(input int id, input tablero_t tab, input bit limp,
                          input tablero_t esp, input logic [15:0] libre,
                          input int lat_min, input int lat_max,
                          input logic g, input logic p);
        esperado_t e;
        @(negedge clk);
        matriz_in = tab;
        limpiar   = limp;
        start     = 1'b1;
        e.id = id;  e.t_start = ciclo + 1;
        e.lat_min = lat_min;  e.lat_max = lat_max;
        e.tablero = esp;  e.libre = libre;  e.modo_limpiar = limp;
        e.gano = g;  e.perdio = p;
        cola.push_back(e);
        @(negedge clk);
        start   = 1'b0;
        limpiar = 1'b0;
        // A board of 2048s after the latch would show up as a win if it leaked in.
        matriz_in = {16{12'd2048}};
        check($sformatf("t%0d ocupado", id), ocupado, 1);
        for (int i = 0; i < 200 && cola.size() != 0; i++) @(negedge clk);
        if (cola.size() != 0) begin
            check($sformatf("t%0d timeout_cola", id), cola.size(), 0);
            cola.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    tablero_t tab_lleno, tab_hueco, esp_hueco, tab_meta, tab_1024;
    int n_done;

    initial begin
        tab_lleno = {12'd2,   12'd4,    12'd8,   12'd16,
                     12'd32,  12'd64,   12'd128, 12'd256,
                     12'd512, 12'd1024, 12'd2,   12'd4,
                     12'd8,   12'd16,   12'd32,  12'd64};
        tab_hueco = {12'd2,   12'd4,  12'd2,   12'd4,
                     12'd4,   12'd8,  12'd4,   12'd2,
                     12'd32,  12'd0,  12'd64,  12'd128,
                     12'd2,   12'd16, 12'd2,   12'd4};
        esp_hueco = tab_hueco;
        esp_hueco[2][1] = 12'hFFF;
        tab_meta = tab_lleno;
        tab_meta[0][0] = 12'd2048;
        tab_meta[3][2] = 12'd64;
        tab_meta[3][3] = 12'd64;
        tab_1024 = {16{12'd1024}};

        rst = 1'b1;  start = 1'b1;  limpiar = 1'b0;  matriz_in = tab_lleno;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;  start = 1'b0;
        check("rst matriz_out", matriz_out, 0);
        check("rst done", done, 0);
        check("rst gano", gano, 0);
        check("rst perdio", perdio, 0);
        check("rst ocupado", ocupado, 0);
        @(negedge clk);
        check("rst start_ignorado", ocupado, 0);

        lanzar(1, tab_lleno, 1'b0, tab_lleno, 16'h0000, 18, 18, 1'b0, 1'b1);
        lanzar(2, tab_hueco, 1'b0, esp_hueco, 16'h0200, 28, 28, 1'b0, 1'b1);
        lanzar(3, tab_meta,  1'b0, tab_meta,  16'h0000, 18, 18, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        check("retencion gano", gano, 1);
        check("retencion tablero", matriz_out, tab_meta);
        lanzar(4, tab_1024, 1'b1, '0, 16'h0000, 36, 66, 1'b0, 1'b0);

        // Abort: start at T, stray start at T+3, reset sampled at T+5.
        @(negedge clk);
        matriz_in = tab_lleno;  start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort ocupado", ocupado, 0);
        check("abort matriz_out", matriz_out, 0);
        check("abort gano", gano, 0);
        check("abort perdio", perdio, 0);
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) n_done++;
        end
        check("abort sin_done", n_done, 0);
        check("abort ocupado_final", ocupado, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/generador_ficha.md
Name: generador_ficha

Overview:
- Tile spawner and end-of-game evaluator for the 2048 board. It sits downstream of the move/merge logic.
- It takes the post-move board, writes one new tile (2 or 4) into a pseudo-randomly chosen empty cell, then flags win or loss.
- It returns the updated board, which the control FSM feeds back as the next move's input.
- On a new game it clears the board and spawns two tiles.

Parameters:
ANCHO, 12, bit width of one tile value (stores actual value: 0 = empty, 2..2048)
META, 2048, tile value that signals a win
SEMILLA, 16'hACE1, LFSR reset value; must be nonzero

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
start  input  1  request one spawn/evaluate pass; sampled only in IDLE
limpiar  input  1  sampled with start; 1 = clear board and spawn two tiles
matriz_in  input  ANCHO x [0:3][0:3]  board after move/merge, indexed [fila][col]
matriz_out  output  ANCHO x [0:3][0:3]  board after spawn, registered
ocupado  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when matriz_out/gano/perdio are updated
gano  output  1  some cell == META (registered, held)
perdio  output  1  no empty cell and no equal orthogonal neighbours (registered, held)

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - matriz_out = all 0; done, gano, perdio, ocupado = 0; FSM = IDLE; LFSR = SEMILLA.
  - rst mid-operation aborts the pass; no done pulse is emitted.
- LFSR:
  - 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1.
  - Advances every cycle regardless of state.
  - rnd is a snapshot of the LFSR taken on entry to CONTAR.
- Cell index k = 4*fila + col, scanned k = 0..15.
- States:
  - IDLE: on start=1, latch board into tablero (all-zero if limpiar=1, else matriz_in), set pendientes = limpiar ? 2 : 1, go to CONTAR. matriz_in is ignored after the latch. start is ignored in any other state.
  - CONTAR: 16 cycles, one cell per cycle; vacias = number of zero cells (0..16). Then:
    - if vacias = 0, go to EVALUAR;
    - else objetivo = (rnd[7:0] * vacias) >> 8, which lies in 0..vacias-1, and go to ELEGIR.
  - ELEGIR: scan one cell per cycle, counting zero cells seen. At the empty cell whose ordinal == objetivo:
    - write 4 if rnd[11:8] < 2, else write 2;
    - decrement pendientes;
    - if pendientes is now nonzero go to CONTAR (fresh rnd snapshot), else go to EVALUAR.
    - Remaining cells are not scanned.
  - EVALUAR: one cycle.
    - gano_n = any cell == META.
    - perdio_n = no zero cell AND no horizontally or vertically adjacent equal nonzero pair (24 comparisons).
  - FIN: matriz_out <= tablero, gano <= gano_n, perdio <= perdio_n, done = 1 for this cycle only; next state IDLE.
- Latency, with start sampled at edge T:
  - CONTAR cell k at T+1+k.
  - ELEGIR cell k at T+17+k.
  - Write at cell k → EVALUAR T+18+k, done T+19+k.
  - vacias = 0 → EVALUAR T+17, done T+18.
  - limpiar=1 adds a second CONTAR+ELEGIR pass starting the cycle after the first write.
- Arithmetic and values:
  - Tile values are never summed here; only 2 or 4 are written.
  - Occupied cells pass through unchanged.
- Boundary conditions:
  - Full board, no merges → board unchanged, perdio=1.
  - Full board containing META → gano=1; perdio is evaluated independently.
  - A board with a single empty cell always receives its tile in that cell.
  - Between passes, outputs hold their last values.

Test Plan:
- Reset: hold rst 2 cycles → matriz_out all 0, done=gano=perdio=ocupado=0. start raised with rst=1 is ignored.
- Single empty cell [2][1] (k=9); other cells a non-merging pattern of powers of two; neighbours of [2][1] are 8, 16, 32, 64 → done at T+28; [2][1] ∈ {2,4}; all other cells unchanged; perdio=1, gano=0.
- Full board, no adjacent equal pair, no 2048 → done at T+18, matriz_out == matriz_in, perdio=1, gano=0.
- Full board with [0][0]=2048 and [3][2]=[3][3]=64 → done at T+18, gano=1, perdio=0, board unchanged.
- limpiar=1 with matriz_in all 1024 → exactly 2 nonzero cells in matriz_out, each 2 or 4, gano=0, perdio=0, a single done pulse.
- Start, then rst=1 at T+5 → ocupado=0 and FSM idle after that edge, no done within 40 cycles, matriz_out all 0. A second start pulse at T+3 (before the reset) has no effect.
